// File: rtl/hazard_step_ctrl.sv
// Pipeline sequencer: run/step/halt control, load-use and branch hazard stalls, stall watchdog.
// Optional saturating perf counters when HSC_PERF_CNT_EN is defined.
module hazard_step_ctrl #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned MAX_STALL = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_halt,
  input  logic             halt_instr,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic             BranchD,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic             MemtoRegM,
  output logic             pipe_en,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             halted,
  output logic             step_done,
  output logic             stall_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned RC_W = $clog2(MAX_STALL) + 1;

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;

  state_t          r_state, w_state_nxt;
  logic [RC_W-1:0] r_run_cnt, w_run_cnt_nxt;
  logic            r_step_done, w_step_done_nxt;
  logic            r_stall_err, w_stall_err_nxt;

  logic w_lwstall, w_brstall, w_pipe_en, w_hz, w_wdog;

  // Hazard detection against producers in E and M
  assign w_lwstall = MemtoRegE & RegWriteE & (RtE != '0) & ((RtE == RsD) | (RtE == RtD));
  assign w_brstall = BranchD &
                     ((RegWriteE & (WriteRegE != '0) & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                      (MemtoRegM & (WriteRegM != '0) & ((WriteRegM == RsD) | (WriteRegM == RtD))));

  assign w_pipe_en = (r_state == S_RUN) | (r_state == S_STEP);
  assign w_hz      = (w_lwstall | w_brstall) & w_pipe_en;
  assign w_wdog    = w_hz & (r_run_cnt == RC_W'(MAX_STALL - 1));

  // Next-state, watchdog and status logic
  always_comb begin
    w_state_nxt     = r_state;
    w_step_done_nxt = 1'b0;
    w_stall_err_nxt = r_stall_err | w_wdog;
    w_run_cnt_nxt   = w_hz ? (r_run_cnt + RC_W'(1)) : '0;
    case (r_state)
      S_HALT: begin
        w_run_cnt_nxt = '0;
        if (cmd_halt) begin
          w_state_nxt = S_HALT;
        end else if (cmd_step) begin
          w_state_nxt = S_STEP;
        end else if (cmd_run) begin
          w_state_nxt     = S_RUN;
          w_stall_err_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (cmd_halt | halt_instr | w_wdog) begin
          w_state_nxt   = S_HALT;
          w_run_cnt_nxt = '0;
        end
      end
      S_STEP: begin
        if (cmd_halt | w_wdog) begin
          w_state_nxt   = S_HALT;
          w_run_cnt_nxt = '0;
        end else if (!w_hz) begin
          w_state_nxt     = S_HALT;
          w_step_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = S_HALT;
        w_run_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_HALT;
      r_run_cnt   <= '0;
      r_step_done <= 1'b0;
      r_stall_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_run_cnt   <= w_run_cnt_nxt;
      r_step_done <= w_step_done_nxt;
      r_stall_err <= w_stall_err_nxt;
    end
  end

  assign pipe_en   = w_pipe_en;
  assign StallF    = w_hz;
  assign StallD    = w_hz;
  assign FlushE    = w_hz;
  assign halted    = (r_state == S_HALT);
  assign step_done = r_step_done;
  assign stall_err = r_stall_err;

`ifdef HSC_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt, r_stall_cnt;

  // Saturating counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pipe_en && (r_cycle_cnt != '1)) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_hz && (r_stall_cnt != '1))      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_step_ctrl.sv
// Scoreboard bench for hazard_step_ctrl: stimulus pushes per-cycle expectations, a monitor pops and compares.
module tb_hazard_step_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_run = 0, cmd_step = 0, cmd_halt = 0, halt_instr = 0;
  logic [4:0]  RsD = 0, RtD = 0, RtE = 0, WriteRegE = 0, WriteRegM = 0;
  logic        BranchD = 0, RegWriteE = 0, MemtoRegE = 0, MemtoRegM = 0;
  logic        pipe_en, StallF, StallD, FlushE, halted, step_done, stall_err;
  logic [31:0] cycle_cnt, stall_cnt;

  hazard_step_ctrl #(.REG_W(5), .MAX_STALL(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
    .halt_instr(halt_instr), .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .RtE(RtE),
    .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM), .pipe_en(pipe_en), .StallF(StallF),
    .StallD(StallD), .FlushE(FlushE), .halted(halted), .step_done(step_done),
    .stall_err(stall_err), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] v;
    bit         chk;
    int         cc;
    int         sc;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] act;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cmd_run = 0; cmd_step = 0; cmd_halt = 0; halt_instr = 0;
    RsD = 0; RtD = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0;
    BranchD = 0; RegWriteE = 0; MemtoRegE = 0; MemtoRegM = 0;
  endtask

  task automatic lw_hz();
    MemtoRegE = 1; RegWriteE = 1; RtE = 5'd5; RsD = 5'd5;
  endtask

  task automatic ex(input string nm, input bit pe, input bit st, input bit h, input bit sd,
                    input bit err, input bit chk = 0, input int cc = 0, input int sc = 0);
    exp_t e;
`ifndef HSC_PERF_CNT_EN
    cc = 0; sc = 0;
`endif
    e.name = nm; e.v = {pe, st, st, st, h, sd, err}; e.chk = chk; e.cc = cc; e.sc = sc;
    sb.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest expectation each cycle
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        me  = sb.pop_front();
        act = {pipe_en, StallF, StallD, FlushE, halted, step_done, stall_err};
        checks++;
        if (act !== me.v || (me.chk && (cycle_cnt !== 32'(me.cc) || stall_cnt !== 32'(me.sc)))) begin
          errors++;
          $display("FAIL %s: got {pe,sF,sD,fE,h,sd,err}=%b cyc=%0d stl=%0d, expected %b cyc=%0d stl=%0d",
                   me.name, act, cycle_cnt, stall_cnt, me.v, me.cc, me.sc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset and start
    reset = 1;
    nxt(); ex("reset_c1", 0, 0, 1, 0, 0);
    nxt(); ex("reset_c2", 0, 0, 1, 0, 0);
    nxt(); ex("reset_c3", 0, 0, 1, 0, 0);
    nxt(); reset = 0; ex("post_reset", 0, 0, 1, 0, 0, 1, 0, 0);
    nxt(); cmd_run = 1; ex("run_cmd", 0, 0, 1, 0, 0);
    nxt(); clr(); ex("run_entered", 1, 0, 0, 0, 0);
    // load-use
    nxt(); lw_hz(); ex("lwstall", 1, 1, 0, 0, 0);
    nxt(); RtE = 0; ex("lw_rt0", 1, 0, 0, 0, 0);
    // branch operand
    nxt(); clr(); BranchD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3; ex("br_e", 1, 1, 0, 0, 0);
    nxt(); clr(); ex("br_clear", 1, 0, 0, 0, 0);
    nxt(); BranchD = 1; MemtoRegM = 1; WriteRegM = 3; RtD = 3; ex("br_m", 1, 1, 0, 0, 0);
    nxt(); clr(); BranchD = 1; MemtoRegM = 1; WriteRegM = 0; RsD = 0; ex("br_m_r0", 1, 0, 0, 0, 0);
    nxt(); clr(); cmd_halt = 1; ex("halt_cmd", 1, 0, 0, 0, 0);
    nxt(); clr(); ex("halted", 0, 0, 1, 0, 0);
    nxt(); lw_hz(); ex("halt_masks_hz", 0, 0, 1, 0, 0);
    // single step, no hazard
    nxt(); clr(); cmd_step = 1; ex("step_cmd", 0, 0, 1, 0, 0);
    nxt(); clr(); ex("step_exec", 1, 0, 0, 0, 0);
    nxt(); ex("step_done", 0, 0, 1, 1, 0);
    nxt(); ex("step_done_pulse", 0, 0, 1, 0, 0);
    // single step held by 2 hazard cycles
    nxt(); cmd_step = 1; ex("step2_cmd", 0, 0, 1, 0, 0);
    nxt(); clr(); lw_hz(); ex("step2_hz1", 1, 1, 0, 0, 0);
    nxt(); ex("step2_hz2", 1, 1, 0, 0, 0);
    nxt(); clr(); ex("step2_exec", 1, 0, 0, 0, 0);
    nxt(); ex("step2_done", 0, 0, 1, 1, 0);
    nxt(); ex("step2_pulse", 0, 0, 1, 0, 0);
    // halt + step together stays halted
    nxt(); cmd_halt = 1; cmd_step = 1; ex("halt_step_cmd", 0, 0, 1, 0, 0);
    nxt(); clr(); ex("halt_beats_step", 0, 0, 1, 0, 0);
    // watchdog
    nxt(); cmd_run = 1; ex("wd_run_cmd", 0, 0, 1, 0, 0);
    nxt(); clr(); ex("wd_run", 1, 0, 0, 0, 0);
    nxt(); lw_hz(); ex("wd_hz1", 1, 1, 0, 0, 0);
    nxt(); ex("wd_hz2", 1, 1, 0, 0, 0);
    nxt(); ex("wd_hz3", 1, 1, 0, 0, 0);
    nxt(); ex("wd_hz4", 1, 1, 0, 0, 0);
    nxt(); ex("wd_tripped", 0, 0, 1, 0, 1);
    nxt(); clr(); cmd_run = 1; ex("wd_sticky", 0, 0, 1, 0, 1);
    nxt(); clr(); ex("wd_cleared_run", 1, 0, 0, 0, 0);
    // step ignored in run
    nxt(); cmd_step = 1; ex("run_step_ign", 1, 0, 0, 0, 0);
    nxt(); clr(); ex("run_still", 1, 0, 0, 0, 0);
    // halt instruction
    nxt(); halt_instr = 1; ex("halt_instr", 1, 0, 0, 0, 0);
    nxt(); clr(); ex("halt_instr_done", 0, 0, 1, 0, 0, 1, 21, 9);
    // reset during a step: no step_done
    nxt(); cmd_step = 1; ex("rst_step_cmd", 0, 0, 1, 0, 0);
    nxt(); clr(); reset = 1; ex("rst_step_exec", 1, 0, 0, 0, 0, 1, 21, 9);
    nxt(); reset = 0; ex("rst_mid_step", 0, 0, 1, 0, 0, 1, 0, 0);
    // 10 run cycles with 2 stalls, ended by halt_instr
    nxt(); cmd_run = 1; ex("cnt_run_cmd", 0, 0, 1, 0, 0);
    nxt(); clr(); ex("cnt_r1", 1, 0, 0, 0, 0);
    nxt(); ex("cnt_r2", 1, 0, 0, 0, 0);
    nxt(); lw_hz(); ex("cnt_r3_hz", 1, 1, 0, 0, 0);
    nxt(); ex("cnt_r4_hz", 1, 1, 0, 0, 0);
    nxt(); clr(); ex("cnt_r5", 1, 0, 0, 0, 0);
    nxt(); ex("cnt_r6", 1, 0, 0, 0, 0);
    nxt(); ex("cnt_r7", 1, 0, 0, 0, 0);
    nxt(); ex("cnt_r8", 1, 0, 0, 0, 0);
    nxt(); ex("cnt_r9", 1, 0, 0, 0, 0);
    nxt(); halt_instr = 1; ex("cnt_r10", 1, 0, 0, 0, 0);
    nxt(); clr(); ex("cnt_final", 0, 0, 1, 0, 0, 1, 10, 2);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
